border_link_aggregator: RTL and testbench

- Downstream of the per-edge neighbour-link FIFO stage. Merges the FWFT output FIFOs of N_LINKS border links into one valid/ready message stream toward the inter-FPGA channel.
- Each message is {type[1:0], root address} and is tagged with its source link index.
- Uses round-robin arbitration and a 2-entry registered output buffer, giving a sustained rate of 1 message per cycle.
- Provides busy and a message count so the stage controller can detect when the border has drained before it advances the stage.

---
 rtl/border_link_aggregator.sv | 165 ++++++++++++++++
 tb/tb_border_link_aggregator.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/border_link_aggregator.sv
// Merges N_LINKS FWFT link FIFOs into one valid/ready stream of {link_index, message}
// using a round-robin grant and a two-entry (main + skid) registered output buffer.
module border_link_aggregator #(
    parameter int PER_DIMENSION_WIDTH = 4,
    parameter int N_LINKS             = 4,
    parameter int COUNT_WIDTH         = 16,
    localparam int ADDRESS_WIDTH      = 3 * PER_DIMENSION_WIDTH,
    localparam int MSG_WIDTH          = ADDRESS_WIDTH + 2,
    localparam int IDX_WIDTH          = $clog2(N_LINKS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           initialize,
    input  logic [N_LINKS*MSG_WIDTH-1:0]   in_data,
    input  logic [N_LINKS-1:0]             in_valid,
    output logic [N_LINKS-1:0]             in_ready,
    output logic [IDX_WIDTH+MSG_WIDTH-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic [COUNT_WIDTH-1:0]         msg_count
);

    localparam int OUT_WIDTH = IDX_WIDTH + MSG_WIDTH;

    logic [1:0]             count_q, count_d;
    logic [OUT_WIDTH-1:0]   main_q, main_d;
    logic [OUT_WIDTH-1:0]   skid_q, skid_d;
    logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
    logic [COUNT_WIDTH-1:0] msg_count_q, msg_count_d;
    logic                   out_valid_q, out_valid_d;

    logic                   flush_s;
    logic                   pop_s;
    logic                   can_grant_s;
    logic                   grant_valid_s;
    logic [IDX_WIDTH-1:0]   grant_idx_s;
    logic [IDX_WIDTH-1:0]   cand_idx_s;
    logic [N_LINKS-1:0]     in_ready_s;
    logic [OUT_WIDTH-1:0]   push_data_s;
    logic [1:0]             after_pop_s;

    assign flush_s     = reset | initialize;
    assign pop_s       = (count_q != 2'd0) & out_ready;
    assign can_grant_s = ~flush_s & ((count_q != 2'd2) | pop_s);

    // Round-robin search starting at the pointer; first valid link wins.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        cand_idx_s    = '0;
        in_ready_s    = '0;
        for (int k = 0; k < N_LINKS; k++) begin
            cand_idx_s = IDX_WIDTH'((int'(ptr_q) + k) % N_LINKS);
            if (can_grant_s && !grant_valid_s && in_valid[cand_idx_s]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = cand_idx_s;
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
        if (grant_valid_s) begin
            in_ready_s[grant_idx_s] = 1'b1;
        end else begin
            in_ready_s = '0;
        end
    end

    assign push_data_s = {grant_idx_s, in_data[grant_idx_s*MSG_WIDTH +: MSG_WIDTH]};
    assign after_pop_s = count_q - {1'b0, pop_s};

    // Buffer, pointer and counter next state; a push lands in the first entry free after the pop.
    always_comb begin
        count_d     = count_q;
        main_d      = main_q;
        skid_d      = skid_q;
        ptr_d       = ptr_q;
        msg_count_d = msg_count_q;
        if (flush_s) begin
            count_d     = 2'd0;
            main_d      = '0;
            skid_d      = '0;
            ptr_d       = '0;
            msg_count_d = '0;
        end else begin
            if (pop_s) begin
                main_d = skid_q;
            end else begin
                main_d = main_q;
            end
            if (grant_valid_s) begin
                if (after_pop_s == 2'd0) begin
                    main_d = push_data_s;
                end else begin
                    skid_d = push_data_s;
                end
                if (grant_idx_s == IDX_WIDTH'(N_LINKS - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = grant_idx_s + 1'b1;
                end
                if (msg_count_q != {COUNT_WIDTH{1'b1}}) begin
                    msg_count_d = msg_count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    msg_count_d = msg_count_q;
                end
            end else begin
                ptr_d = ptr_q;
            end
            count_d = after_pop_s + {1'b0, grant_valid_s};
        end
        out_valid_d = (count_d != 2'd0);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= 2'd0;
            main_q      <= '0;
            skid_q      <= '0;
            ptr_q       <= '0;
            msg_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            ptr_q       <= ptr_d;
            msg_count_q <= msg_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = main_q;
    assign out_valid = out_valid_q;
    assign busy      = (|in_valid) | (count_q != 2'd0);
    assign msg_count = msg_count_q;

    border_link_aggregator_chk #(.N_LINKS(N_LINKS)) u_chk (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready_s)
    );

endmodule

// Pop strobes must be one-hot-or-zero and only toward links that hold data.
module border_link_aggregator_chk #(
    parameter int N_LINKS = 4
) (
    input logic               clk,
    input logic               reset,
    input logic [N_LINKS-1:0] in_valid,
    input logic [N_LINKS-1:0] in_ready
);

    a_ready_needs_valid: assert property (@(posedge clk) disable iff (reset)
        ((in_ready & ~in_valid) == '0));

    a_ready_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(in_ready));

endmodule

// File: tb/tb_border_link_aggregator.sv
// Bench for border_link_aggregator: hand-written vector table, round-robin run,
// randomized traffic against a queue-based reference model, and counter saturation.
module tb_border_link_aggregator;

    localparam int NL = 4;
    localparam int MW = 14;
    localparam int IW = 2;
    localparam int OW = IW + MW;

    logic              clk = 1'b0;
    logic              reset, initialize;
    logic [NL*MW-1:0]  in_data;
    logic [NL-1:0]     in_valid, in_ready, in_ready4;
    logic [OW-1:0]     out_data, out_data4;
    logic              out_valid, out_valid4, out_ready, busy, busy4;
    logic [15:0]       msg_count;
    logic [3:0]        msg_count4;

    border_link_aggregator dut (
        .clk(clk), .reset(reset), .initialize(initialize), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .msg_count(msg_count)
    );

    border_link_aggregator #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .initialize(initialize), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready), .busy(busy4), .msg_count(msg_count4)
    );

    always #5 clk = ~clk;

    // Reference model: the output buffer is simply a FIFO of at most two tagged messages.
    logic [OW-1:0] mq[$];
    int            ptr_m, cnt_m, cnt4_m;
    bit            cleared_m;
    logic [NL-1:0] last_ir;
    logic          last_busy;
    int            checks = 0;
    int            errors = 0;

    typedef struct {
        logic       rst;
        logic       ini;
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] ir;
        logic       bsy;
        logic       ov;
        int         link;
        int         mc;
    } vec_t;

    vec_t          tbl[15];
    logic [MW-1:0] ld[NL];
    logic [NL*MW-1:0] din_fix;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic cycle(input logic rst, input logic ini, input logic [NL-1:0] iv,
                         input logic ordy, input logic [NL*MW-1:0] din);
        bit            pop_m, allow_m;
        int            g;
        logic [NL-1:0] exp_ir;
        reset      = rst;
        initialize = ini;
        in_valid   = iv;
        out_ready  = ordy;
        in_data    = din;
        #3;
        pop_m   = (mq.size() > 0) && ordy;
        allow_m = !rst && !ini && ((mq.size() < 2) || pop_m);
        g = -1;
        if (allow_m) begin
            for (int k = 0; k < NL; k++) begin
                int i;
                i = (ptr_m + k) % NL;
                if (g < 0 && iv[i]) g = i;
            end
        end
        exp_ir = (g >= 0) ? (NL'(1) << g) : NL'(0);
        chk("in_ready", in_ready, exp_ir);
        chk("busy", busy, ((iv != 0) || (mq.size() > 0)) ? 64'd1 : 64'd0);
        last_ir   = in_ready;
        last_busy = busy;
        @(posedge clk);
        #1;
        if (rst || ini) begin
            mq.delete();
            ptr_m = 0; cnt_m = 0; cnt4_m = 0; cleared_m = 1'b1;
        end else begin
            if (pop_m) void'(mq.pop_front());
            if (g >= 0) begin
                mq.push_back({IW'(g), din[g*MW +: MW]});
                ptr_m  = (g + 1) % NL;
                cnt_m  = (cnt_m < 65535) ? cnt_m + 1 : cnt_m;
                cnt4_m = (cnt4_m < 15) ? cnt4_m + 1 : cnt4_m;
                cleared_m = 1'b0;
            end
        end
        chk("out_valid", out_valid, (mq.size() > 0) ? 64'd1 : 64'd0);
        if (mq.size() > 0) chk("out_data", out_data, mq[0]);
        else if (cleared_m) chk("out_data_clr", out_data, 64'd0);
        chk("msg_count", msg_count, cnt_m);
        chk("msg_count4", msg_count4, cnt4_m);
    endtask

    initial begin
        ld[0] = 14'h1111; ld[1] = 14'h2222; ld[2] = 14'h2ABC; ld[3] = 14'h3333;
        din_fix = {ld[3], ld[2], ld[1], ld[0]};
        //                rst   ini   iv       ordy  ir       bsy   ov   link mc
        tbl[0]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 2, 1};
        tbl[2]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 0, 1};
        tbl[3]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 0, 1};
        tbl[4]  = '{1'b0, 1'b1, 4'b0011, 1'b0, 4'b0000, 1'b1, 1'b0, 0, 0};
        tbl[5]  = '{1'b0, 1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 1'b1, 0, 1};
        tbl[6]  = '{1'b0, 1'b0, 4'b0011, 1'b0, 4'b0010, 1'b1, 1'b1, 0, 2};
        tbl[7]  = '{1'b0, 1'b0, 4'b0011, 1'b0, 4'b0000, 1'b1, 1'b1, 0, 2};
        tbl[8]  = '{1'b0, 1'b0, 4'b0011, 1'b1, 4'b0001, 1'b1, 1'b1, 1, 3};
        tbl[9]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 0, 3};
        tbl[10] = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 0, 3};
        tbl[11] = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b1, 1, 4};
        tbl[12] = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b1, 1, 5};
        tbl[13] = '{1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0, 0, 0};
        tbl[14] = '{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 0, 1};

        reset = 1'b1; initialize = 1'b0; in_valid = '0; out_ready = 1'b0; in_data = '0;
        mq.delete(); ptr_m = 0; cnt_m = 0; cnt4_m = 0; cleared_m = 1'b1;
        @(posedge clk);
        #1;

        // Single message, backpressure and initialize sequences from the table.
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].rst, tbl[i].ini, tbl[i].iv, tbl[i].ordy, din_fix);
            chk("tbl_ir", last_ir, tbl[i].ir);
            chk("tbl_busy", last_busy, tbl[i].bsy);
            chk("tbl_ov", out_valid, tbl[i].ov);
            if (tbl[i].ov) chk("tbl_data", out_data, {IW'(tbl[i].link), ld[tbl[i].link]});
            chk("tbl_mc", msg_count, tbl[i].mc);
        end

        // All links valid, output always ready: strict rotation, one beat per cycle.
        cycle(1'b1, 1'b0, 4'b0000, 1'b1, din_fix);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 1'b0, 4'b1111, 1'b1, din_fix);
            chk("rr_order", last_ir, NL'(1) << (k % NL));
            chk("rr_beat", out_valid, 64'd1);
            chk("rr_tag", out_data[OW-1 -: IW], k % NL);
        end
        chk("sat4_stop", msg_count4, 64'd15);
        chk("count20", msg_count, 64'd20);

        // Randomized traffic, mostly dense so full-buffer push+pop is exercised.
        for (int k = 0; k < 400; k++) begin
            logic [NL-1:0]    iv_r;
            logic             ordy_r, ini_r;
            logic [NL*MW-1:0] din_r;
            iv_r   = NL'($urandom_range(0, 15)) | NL'($urandom_range(0, 15));
            ordy_r = ($urandom_range(0, 4) != 0);
            ini_r  = ($urandom_range(0, 79) == 0);
            din_r  = (NL*MW)'({$urandom(), $urandom()});
            cycle(1'b0, ini_r, iv_r, ordy_r, din_r);
        end

        // Drain and confirm idle.
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 4'b0000, 1'b1, din_fix);
        chk("drained_busy", busy, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
